// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the FSM state encoding and the timing/width defaults.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } hz_state_e;

    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int CNT_W_DEF       = 16;
    localparam int WAIT_W_MIN      = 8;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// The pipeline (master) reports its stage contents; the hazard controller (slave) returns the stage enables.
interface hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_branch_taken;
    logic       mem_req;
    logic       dmem_ready;

    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       ex_mem_write;
    logic       id_ex_bubble;
    logic       mem_wb_bubble;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       pc_src;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               mem_branch_taken, mem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
               mem_wb_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pc_src
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               mem_branch_taken, mem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
               mem_wb_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pc_src
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
    always_comb begin
        rs1_hit  = id_use_rs1 & (ex_rd == id_rs1);
        rs2_hit  = id_use_rs2 & (ex_rd == id_rs2);
        load_use = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory wait > taken branch > load-use into stage
// enables, tracks the winning event in a small FSM and keeps stall/flush/timeout statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > WAIT_W_MIN) ?
                            $clog2(TIMEOUT_CYC + 1) : WAIT_W_MIN;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYC);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic mem_wait_act;
    logic branch_act;
    logic load_act;

    hazard_detect u_detect (
        .ex_mem_read (hz.ex_mem_read),
        .ex_rd       (hz.ex_rd),
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_use_rs1  (hz.id_use_rs1),
        .id_use_rs2  (hz.id_use_rs2),
        .load_use    (load_use)
    );

    // Exactly one event acts per cycle; all are masked while reset is asserted.
    // The slot behind a flush is a bubble, so a branch seen in FLUSH is stale.
    always_comb begin
        mem_wait_act = reset & hz.mem_req & ~hz.dmem_ready;
        branch_act   = reset & ~mem_wait_act & hz.mem_branch_taken & (state_q != ST_FLUSH);
        load_act     = reset & ~mem_wait_act & ~branch_act & load_use;
    end

    assign hz.pc_write      = ~(mem_wait_act | load_act);
    assign hz.if_id_write   = ~(mem_wait_act | load_act);
    assign hz.id_ex_write   = ~mem_wait_act;
    assign hz.ex_mem_write  = ~mem_wait_act;
    assign hz.id_ex_bubble  = load_act;
    assign hz.mem_wb_bubble = mem_wait_act;
    assign hz.if_id_flush   = branch_act;
    assign hz.id_ex_flush   = branch_act;
    assign hz.ex_mem_flush  = branch_act;
    assign hz.pc_src        = branch_act;

    always_comb begin
        state_d       = ST_RUN;
        wait_cnt_d    = '0;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        mem_timeout_d = mem_timeout_q;

        if (mem_wait_act) begin
            state_d = ST_MEM_WAIT;
        end else if (branch_act) begin
            state_d = ST_FLUSH;
        end else if (load_act) begin
            state_d = ST_LOAD_STALL;
        end

        if (mem_wait_act) begin
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d >= WAIT_LIMIT) begin
                mem_timeout_d = 1'b1;
            end
        end

        if ((mem_wait_act | load_act) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_act && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, the maximum MEM-wait length before the timeout flag sets.
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 id_rs1, id_rs2  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  the instruction in ID actually reads rs1 / rs2.
REQ-007 ex_mem_read  input  1  the instruction in EX is a load.
REQ-008 ex_rd  input  5  destination register of the instruction in EX.
REQ-009 mem_branch_taken  input  1  the branch in MEM is resolved taken.
REQ-010 mem_req  input  1  the MEM stage is issuing a data-memory access.
REQ-011 dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 pc_write, if_id_write, id_ex_write, ex_mem_write  output  1 each  stage-register enables (1 = advance).
REQ-013 id_ex_bubble, mem_wb_bubble  output  1 each  force zero control bits into ID/EX or MEM/WB.
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  clear the stage register.
REQ-015 pc_src  output  1  PC loads the branch target.
REQ-016 state  output  2  current FSM state.
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  performance counters.
REQ-018 mem_timeout  output  1  sticky error flag.

Function
REQ-019 Load-use hazard SHALL be: ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
REQ-020 Memory wait SHALL be: mem_req & ~dmem_ready.
REQ-021 All control outputs SHALL be combinational from the current inputs, with zero-cycle latency.
REQ-022 Defaults, with no event: all write enables 1; all bubble, flush and pc_src outputs 0.
REQ-023 Priority SHALL be: memory wait, then taken branch, then load-use; only the winner acts.
REQ-024 Memory wait SHALL drive pc_write, if_id_write, id_ex_write and ex_mem_write to 0, and mem_wb_bubble to 1.
REQ-025 Taken branch SHALL drive if_id_flush, id_ex_flush, ex_mem_flush and pc_src to 1.
REQ-026 Load-use SHALL drive pc_write and if_id_write to 0, and id_ex_bubble to 1, for exactly that cycle.
REQ-027 FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.
REQ-028 The next state SHALL be the winning event's state (MEM_WAIT, FLUSH or LOAD_STALL), else RUN, from any state.
REQ-029 In FLUSH, mem_branch_taken SHALL be ignored because the flushed slot cannot branch; a memory wait still wins.
REQ-030 A wait counter SHALL count consecutive MEM_WAIT cycles (8 bits minimum, saturating) and clear on leaving MEM_WAIT.
REQ-031 mem_timeout SHALL set when the wait count reaches TIMEOUT_CYC, stay set until reset, and leave the freeze behaviour unchanged.
REQ-032 stall_cnt SHALL increment on every cycle with a load-use or memory-wait action and saturate at all-ones.
REQ-033 flush_cnt SHALL increment once per acted-on taken branch and saturate at all-ones.
REQ-034 Register 0 SHALL never cause a hazard.
REQ-035 Load-use SHALL not re-fire in LOAD_STALL, because the bubble has ex_mem_read=0; the bench checks this with an assertion.

Reset
REQ-036 With reset=0 at a clock edge: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-037 While reset=0, the combinational outputs SHALL take the REQ-022 defaults regardless of the other inputs.
REQ-038 A reset in MEM_WAIT or FLUSH SHALL take effect at that edge; no partial flush or stall persists.

Structure
REQ-039 The FSM state encodings and the TIMEOUT_CYC default SHALL live in the shared pipeline package.
REQ-040 The block SHALL contain one sub-module, hazard_detect, a combinational load-use comparator per REQ-019.
REQ-041 The block SHALL contain no memories and no latches.

Verification
REQ-042 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle state=1, stall_cnt=1.
REQ-043 x0 case: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall; state stays 0.
REQ-044 Branch: mem_branch_taken=1 for one cycle -> three flushes and pc_src=1; next cycle state=3, flush_cnt=1.
REQ-045 Simultaneous events: mem_req=1, dmem_ready=0, mem_branch_taken=1, load-use true -> only the freeze outputs act; state=2.
REQ-046 Timeout: hold mem_req=1, dmem_ready=0 for 255 cycles -> mem_timeout=1 after the 255th edge and still 1 after dmem_ready=1.
REQ-047 Reset mid-wait: reset=0 for one edge during MEM_WAIT with stall_cnt=40 -> state=0, stall_cnt=0, mem_timeout=0.
